// File: rtl/sd_audio_pkg.sv
// sd_audio_pkg: register offsets and bit positions shared by the sd_audio DAC.
package sd_audio_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_SAMPLE = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_THRESH_LO = 4;
  localparam int CTRL_THRESH_HI = 7;
  // writable CTRL bits: RUN, IRQ_EN and LOW_THRESH; CTRL[3:2] read as zero
  localparam logic [7:0] CTRL_MASK = 8'hF3;

  localparam int STAT_EMPTY    = 8;
  localparam int STAT_FULL     = 9;
  localparam int STAT_UNDERRUN = 10;

endpackage

// File: rtl/sd_audio_fifo.sv
// sd_audio_fifo: synchronous sample FIFO with level/full/empty.
// A push to a full FIFO is accepted only when a pop happens in the same cycle.
module sd_audio_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // pointers and occupancy count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sd_audio.sv
// sd_audio: memory-mapped mono sigma-delta audio DAC (PicoRV32 native bus).
// Optional macro SD_AUDIO_SECOND_ORDER_EN selects a second-order modulator;
// the default build uses a first-order modulator.
module sd_audio
  import sd_audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_W   = 16,
  parameter int DIV_RESET  = 1133
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        left_o,
  output logic        irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]          ctrl;
  logic [15:0]         div;
  logic [15:0]         div_cnt;
  logic                tick;
  logic                underrun;
  logic [SAMPLE_W-1:0] sample;
  logic                accept;
  logic                wr;
  logic [1:0]          addr;
  logic [31:0]         rd_word;
  logic                push;
  logic [SAMPLE_W-1:0] head;
  logic [LW-1:0]       level;
  logic                full;
  logic                empty;
  logic                run;
  logic                unused_bits;

  assign unused_bits = ^{mem_instr, mem_addr, mem_wdata};

  assign accept = enable & mem_valid & ~mem_ready;
  assign wr     = |mem_wstrb;
  assign addr   = mem_addr[3:2];
  assign run    = ctrl[CTRL_RUN];
  assign push   = accept & wr & (addr == REG_SAMPLE);
  assign tick   = run & (div_cnt >= div);

  sd_audio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (tick),
    .wdata   (mem_wdata[SAMPLE_W-1:0]),
    .rdata   (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // read mux for the currently addressed register
  always_comb begin
    rd_word = '0;
    case (addr)
      REG_CTRL:   rd_word = {24'd0, ctrl};
      REG_STATUS: rd_word = {21'd0, underrun, full, empty, 8'(level)};
      REG_DIV:    rd_word = {16'd0, div};
      default:    rd_word = '0;
    endcase
  end

  // bus handshake, read data and CTRL/DIV writes with byte strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      ctrl      <= '0;
      div       <= 16'(DIV_RESET);
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !wr) ? rd_word : '0;
      if (accept && wr) begin
        if (addr == REG_CTRL && mem_wstrb[0]) ctrl <= mem_wdata[7:0] & CTRL_MASK;
        if (addr == REG_DIV) begin
          if (mem_wstrb[0]) div[7:0]  <= mem_wdata[7:0];
          if (mem_wstrb[1]) div[15:8] <= mem_wdata[15:8];
        end
      end
    end
  end

  // underrun flag: set by a tick on an empty FIFO, cleared by write-one to STATUS
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else if (tick && empty) begin
      underrun <= 1'b1;
    end else if (accept && wr && addr == REG_STATUS && mem_wstrb[1] &&
                 mem_wdata[STAT_UNDERRUN]) begin
      underrun <= 1'b0;
    end
  end

  // sample-rate divider counting 0..div, held at zero while stopped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (!run) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // current sample: load FIFO head on tick, otherwise keep the last one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           sample <= '0;
    else if (tick && !empty) sample <= head;
  end

  // low-level refill interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_o <= 1'b0;
    else irq_o <= ctrl[CTRL_IRQ_EN] & run &
                  (int'(level) <= int'(ctrl[CTRL_THRESH_HI:CTRL_THRESH_LO]));
  end

`ifdef SD_AUDIO_SECOND_ORDER_EN
  localparam int MW = SAMPLE_W + 2;
  localparam logic signed [MW-1:0] FB_POS = {3'b001, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [MW-1:0] FB_NEG = -FB_POS;

  logic signed [MW-1:0] int1;
  logic signed [MW-1:0] int2;
  logic signed [MW-1:0] int1_next;
  logic signed [MW-1:0] int2_next;
  logic signed [MW-1:0] x_ext;
  logic signed [MW-1:0] fb;

  assign x_ext     = {{2{sample[SAMPLE_W-1]}}, sample};
  assign fb        = left_o ? FB_POS : FB_NEG;
  assign int1_next = int1 + x_ext - fb;
  assign int2_next = int2 + int1_next - fb;

  // second-order error-feedback loop; output bit is the sign of integrator 2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || !run) begin
      int1   <= '0;
      int2   <= '0;
      left_o <= 1'b0;
    end else begin
      int1   <= int1_next;
      int2   <= int2_next;
      left_o <= ~int2_next[MW-1];
    end
  end
`else
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W:0]   acc_sum;

  // offset-binary input: MSB inverted, carry out is the bitstream
  assign acc_sum = {1'b0, acc} + {1'b0, ~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};

  // first-order accumulator and registered carry output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      left_o <= 1'b0;
    end else if (!run) begin
      acc    <= '0;
      left_o <= 1'b0;
    end else begin
      acc    <= acc_sum[SAMPLE_W-1:0];
      left_o <= acc_sum[SAMPLE_W];
    end
  end
`endif

endmodule

// File: tb/tb_sd_audio.sv
// tb_sd_audio: directed self-checking bench for sd_audio.
module tb_sd_audio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_rdata;
  logic        left_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  sd_audio dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .left_o    (left_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    @(negedge clk);
    enable = 1'b1; mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    @(posedge clk); #1;
    check("bus_ready", {31'd0, mem_ready}, 32'd1);
    r = mem_rdata;
    enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(posedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_xfer(a, d, 4'hF, r);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
    bus_xfer(a, 32'd0, 4'h0, r);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      @(negedge clk);
      ones += int'(left_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int ones;
    int pulses;
    int waited;
    logic seen;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_left", {31'd0, left_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    bus_read(32'hC, r); check("rst_div", r, 32'd1133);
    bus_read(32'h8, r); check("rst_status", r, 32'h100);
    bus_read(32'h0, r); check("rst_ctrl", r, 32'h0);

    // single-cycle enable with mem_valid held: exactly one ready pulse
    @(negedge clk);
    enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h1; mem_wstrb = 4'hF;
    @(posedge clk); #1;
    enable = 1'b0;
    check("hs_ready_after_accept", {31'd0, mem_ready}, 32'd1);
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      pulses += int'(mem_ready);
    end
    check("hs_no_extra_pulse", 32'(pulses), 32'd0);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    bus_read(32'h0, r); check("hs_ctrl_readback", r, 32'h1);
    bus_write(32'h0, 32'h0);

    // held request is re-accepted after each ready pulse
    @(negedge clk);
    enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'hC; mem_wstrb = 4'h0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      pulses += int'(mem_ready);
    end
    enable = 1'b0; mem_valid = 1'b0;
    check("hs_reaccept_pulses", 32'(pulses), 32'd2);
    @(posedge clk);

    // modulator density for mid, max and min samples
    bus_write(32'hC, 32'd9);
    bus_write(32'h0, 32'h1);
    bus_write(32'h4, 32'h0000);
    repeat (30) @(posedge clk);
    count_ones(1000, ones); check("dens_mid", 32'(ones), 32'd500);
    bus_write(32'h4, 32'h7FFF);
    repeat (30) @(posedge clk);
    count_ones(1000, ones); check("dens_max_ge999", {31'd0, ones >= 999}, 32'd1);
    bus_write(32'h4, 32'h8000);
    repeat (30) @(posedge clk);
    count_ones(1000, ones); check("dens_min", 32'(ones), 32'd0);

    // overfill, drain, underrun set/clear
    bus_write(32'h0, 32'h0);
    bus_write(32'h8, 32'h400);
    bus_read(32'h8, r); check("fill_clean", r, 32'h100);
    for (int i = 0; i < 17; i++) bus_write(32'h4, 32'h1234 + i);
    bus_read(32'h8, r); check("fill_full", r, 32'h210);
    bus_write(32'h0, 32'h1);
    repeat (200) @(posedge clk);
    bus_write(32'h0, 32'h0);
    bus_read(32'h8, r); check("drain_underrun", r, 32'h500);
    bus_write(32'h8, 32'h400);
    bus_read(32'h8, r); check("underrun_clear", r, 32'h100);

    // low-level interrupt
    bus_write(32'hC, 32'd99);
    for (int i = 0; i < 6; i++) bus_write(32'h4, 32'h4000);
    bus_read(32'h8, r); check("irq_level6", r, 32'h006);
    check("irq_off_stopped", {31'd0, irq_o}, 32'd0);
    bus_write(32'h0, 32'h43);
    repeat (50) @(negedge clk);
    check("irq_above_thresh", {31'd0, irq_o}, 32'd0);
    seen = 1'b0; waited = 0;
    while (!seen && waited < 400) begin
      @(negedge clk);
      seen = irq_o;
      waited++;
    end
    check("irq_rise", {31'd0, seen}, 32'd1);
    bus_read(32'h8, r); check("irq_level_at_rise", r & 32'hFF, 32'd4);
    bus_write(32'h4, 32'h4000);
    bus_write(32'h4, 32'h4000);
    repeat (2) @(negedge clk);
    check("irq_refill_clear", {31'd0, irq_o}, 32'd0);
    bus_read(32'h8, r); check("irq_level_refill", r & 32'hFF, 32'd6);

    // asynchronous reset mid-stream with a pending ready
    seen = 1'b0; waited = 0;
    while (!seen && waited < 400) begin
      @(negedge clk);
      seen = irq_o;
      waited++;
    end
    check("pre_reset_irq", {31'd0, seen}, 32'd1);
    seen = 1'b0; waited = 0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h8; mem_wstrb = 4'h0;
      @(posedge clk); #1;
      enable = 1'b0; mem_valid = 1'b0;
      seen = left_o & mem_ready;
      if (!seen) @(posedge clk);
      waited++;
    end
    check("pre_reset_left_ready", {31'd0, seen}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, mem_ready}, 32'd0);
    check("async_rst_left", {31'd0, left_o}, 32'd0);
    check("async_rst_irq", {31'd0, irq_o}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    bus_read(32'h8, r); check("post_rst_status", r, 32'h100);
    bus_read(32'h0, r); check("post_rst_ctrl", r, 32'h0);
    bus_read(32'hC, r); check("post_rst_div", r, 32'd1133);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
